universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/usr_pkg.sv | 11 +
 rtl/universal_shift_reg.sv | 40 ++++
 tb/tb_universal_shift_reg.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Operation codes shared by the universal shift register and anything that drives its select input.
package usr_pkg;

  typedef enum logic [1:0] {
    USR_HOLD        = 2'd0,
    USR_SHIFT_RIGHT = 2'd1,
    USR_SHIFT_LEFT  = 2'd2,
    USR_LOAD        = 2'd3
  } usr_op_e;

endpackage

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with hold, serial shift right/left and parallel load; one-cycle latency.
// No backpressure: every clock edge applies the selected operation; the serial outputs are taps of the register.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout
);

  logic [WIDTH-1:0] p_dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_dout_q <= '0;
    end else begin
      case (usr_op_e'(select))
        USR_HOLD:        p_dout_q <= p_dout_q;
        USR_SHIFT_RIGHT: p_dout_q <= {s_right_din, p_dout_q[WIDTH-1:1]};
        USR_SHIFT_LEFT:  p_dout_q <= {p_dout_q[WIDTH-2:0], s_left_din};
        USR_LOAD:        p_dout_q <= p_din;
        default:         p_dout_q <= p_dout_q;
      endcase
    end
  end

  // The serial outputs are the bits each shift direction discards next.
  assign p_dout       = p_dout_q;
  assign s_left_dout  = p_dout_q[0];
  assign s_right_dout = p_dout_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed and randomized checks of universal_shift_reg against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   select = 2'd0;
  logic [W-1:0] p_din = '0;
  logic         s_left_din = 1'b0;
  logic         s_right_din = 1'b0;
  logic [W-1:0] p_dout;
  logic         s_left_dout;
  logic         s_right_dout;

  int total = 0;
  int bad = 0;
  int model = 0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .select       (select),
    .p_din        (p_din),
    .s_left_din   (s_left_din),
    .s_right_din  (s_right_din),
    .p_dout       (p_dout),
    .s_left_dout  (s_left_dout),
    .s_right_dout (s_right_dout)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on the register value.
  function automatic int ref_next(int v, int sel, int din, int sl, int sr);
    int mask;
    mask = (1 << W) - 1;
    case (sel)
      0:       return v;
      1:       return (v / 2) + sr * (1 << (W - 1));
      2:       return ((v * 2) + sl) & mask;
      default: return din & mask;
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".p_dout"}, int'(p_dout), model);
    check({tag, ".s_left_dout"}, int'(s_left_dout), model % 2);
    check({tag, ".s_right_dout"}, int'(s_right_dout), (model >> (W - 1)) % 2);
  endtask

  // Drive inputs, take one rising edge, advance the model, check #1 later.
  task automatic step(input int sel, input int din, input int sl, input int sr, input string tag);
    select      = 2'(sel);
    p_din       = W'(din);
    s_left_din  = 1'(sl);
    s_right_din = 1'(sr);
    @(posedge clk);
    if (rst_n) model = ref_next(model, sel, din, sl, sr);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, check immediate clear, ignore edges, release before a rising edge.
  task automatic reset_mid_cycle(input string tag);
    #2 rst_n = 1'b0;
    model = 0;
    #1 check_all({tag, ".async"});
    select = 2'd3;
    p_din  = 4'b1111;
    @(posedge clk);
    #1 check_all({tag, ".edge_ignored"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sr_exp[4];
    int sl_exp[4];
    sr_exp = '{4'b0110, 4'b0011, 4'b0001, 4'b0000};
    sl_exp = '{4'b1011, 4'b0111, 4'b1111, 4'b1111};

    // Power-on reset
    #2 check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Load then reset without a clock edge
    step(3, 4'b1101, 0, 0, "load_pre_reset");
    check("load_pre_reset.const", int'(p_dout), 4'b1101);
    reset_mid_cycle("reset_nonzero");
    check("reset_nonzero.const", int'(p_dout), 0);

    // Load 1101
    step(3, 4'b1101, 0, 0, "load1101");
    check("load1101.const", int'(p_dout), 4'b1101);

    // Shift right with 0 entering
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, $sformatf("shr%0d", i));
      check($sformatf("shr%0d.const", i), int'(p_dout), sr_exp[i]);
    end

    // Shift left with 1 entering
    step(3, 4'b1101, 0, 0, "reload1101");
    for (int i = 0; i < 4; i++) begin
      step(2, 0, 1, 0, $sformatf("shl%0d", i));
      check($sformatf("shl%0d.const", i), int'(p_dout), sl_exp[i]);
    end

    // Hold with toggling data inputs
    step(3, 4'b1011, 0, 0, "load1011");
    for (int i = 0; i < 6; i++) begin
      step(0, (i % 2 == 0) ? 4'b0100 : 4'b1111, i % 2, (i + 1) % 2, $sformatf("hold%0d", i));
      check($sformatf("hold%0d.const", i), int'(p_dout), 4'b1011);
    end

    // Reset in the middle of a shift-right run
    step(3, 4'b1101, 0, 0, "mid_load");
    step(1, 0, 0, 1, "mid_shr");
    select = 2'd1;
    reset_mid_cycle("mid_shift_reset");
    step(3, 4'b1101, 0, 0, "post_reset_load");
    check("post_reset_load.const", int'(p_dout), 4'b1101);

    // Randomized operations with occasional asynchronous reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_mid_cycle($sformatf("rnd_rst%0d", i));
      end else begin
        step(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
